// File: rtl/fib_request_arbiter.sv
// fib_request_arbiter: round-robin sharing of one Fibonacci core among NUM_REQ requesters,
// with range checking and a watchdog that aborts a hung core.
module fib_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int MAX_N   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [5*NUM_REQ-1:0] req_num,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [15:0]          resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 fib_go,
    output logic [4:0]           fib_number_in,
    output logic                 fib_reset,
    input  logic                 fib_done,
    input  logic [15:0]          fib_number_out
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, id_q, id_d, win;
    logic [4:0]          num_q, num_d, sel_num;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d, found;
    logic [15:0]         data_q, data_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic                resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [15:0]         resp_data_q, resp_data_d;
    logic                busy_q, busy_d, fib_go_q, fib_go_d, fib_reset_q, fib_reset_d;
    logic [4:0]          fib_number_in_q, fib_number_in_d;

    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                win = ID_W'(idx);
                found = 1'b1;
            end
        end
        sel_num = req_num[5*win +: 5];
    end

    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d = id_q;
        num_d = num_q;
        wd_d = wd_q;
        err_d = err_q;
        data_d = data_q;
        req_ack_d = '0;
        resp_valid_d = 1'b0;
        resp_id_d = '0;
        resp_data_d = '0;
        resp_err_d = 1'b0;
        fib_go_d = 1'b0;
        fib_number_in_d = '0;
        fib_reset_d = 1'b1;
        case (state_q)
            IDLE: if (found) begin
                id_d = win;
                num_d = sel_num;
                req_ack_d[win] = 1'b1;
                wd_d = '0;
                err_d = sel_num > 5'(MAX_N);
                data_d = '0;
                state_d = (sel_num > 5'(MAX_N)) ? RESPOND : LAUNCH;
            end
            LAUNCH: begin
                fib_go_d = 1'b1;
                fib_number_in_d = num_q;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // first WAIT cycle may still see done left over from the previous job
                if (wd_q != '0 && fib_done) begin
                    data_d = fib_number_out;
                    err_d = 1'b0;
                    state_d = RESPOND;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    fib_reset_d = 1'b0;
                    data_d = '0;
                    err_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid_d = 1'b1;
                resp_id_d = id_q;
                resp_data_d = err_q ? '0 : data_q;
                resp_err_d = err_q;
                rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                wd_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            id_q <= '0;
            num_q <= '0;
            wd_q <= '0;
            err_q <= 1'b0;
            data_q <= '0;
            req_ack_q <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q <= '0;
            resp_data_q <= '0;
            resp_err_q <= 1'b0;
            busy_q <= 1'b0;
            fib_go_q <= 1'b0;
            fib_number_in_q <= '0;
            fib_reset_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q <= id_d;
            num_q <= num_d;
            wd_q <= wd_d;
            err_q <= err_d;
            data_q <= data_d;
            req_ack_q <= req_ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q <= resp_err_d;
            busy_q <= busy_d;
            fib_go_q <= fib_go_d;
            fib_number_in_q <= fib_number_in_d;
            fib_reset_q <= fib_reset_d;
        end
    end

    assign req_ack = req_ack_q;
    assign resp_valid = resp_valid_q;
    assign resp_id = resp_id_q;
    assign resp_data = resp_data_q;
    assign resp_err = resp_err_q;
    assign busy = busy_q;
    assign fib_go = fib_go_q;
    assign fib_number_in = fib_number_in_q;
    assign fib_reset = fib_reset_q;
endmodule

// File: tb/tb_fib_request_arbiter.sv
// tb_fib_request_arbiter: randomized and directed stimulus against a round-robin
// reference model and a behavioural Fibonacci core, checked through a response scoreboard.
module tb_fib_request_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [19:0] req_num = '0;
    logic [3:0]  req_ack;
    logic        resp_valid, resp_err, busy, fib_go, fib_reset;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic [4:0]  fib_number_in;
    logic        fib_done = 1'b0;
    logic [15:0] fib_number_out = '0;

    fib_request_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_num(req_num), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .fib_go(fib_go), .fib_number_in(fib_number_in),
        .fib_reset(fib_reset), .fib_done(fib_done), .fib_number_out(fib_number_out)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [15:0] data; logic err;} exp_t;
    exp_t q[$];
    int   ack_log[$];
    int   vectors = 0, miscompares = 0;
    int   mptr = 0, lat_fix = 3;
    logic hang = 1'b0, rnd_en = 1'b0, exp_go = 1'b0;
    logic [4:0]  exp_num = '0;
    logic [3:0]  req_seen = '0;
    logic [19:0] num_seen = '0;

    function automatic logic [15:0] fib(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return 16'(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural core: result after a latency, done held until the next go.
    int core_cnt = 0;
    logic core_busy = 1'b0;
    logic [4:0] core_n = '0;
    always @(posedge clk) begin
        if (!fib_reset) begin
            fib_done <= 1'b0;
            fib_number_out <= '0;
            core_busy <= 1'b0;
        end else if (fib_go) begin
            core_busy <= !hang;
            core_cnt <= lat_fix != 0 ? lat_fix : int'($urandom_range(1, 5));
            core_n <= fib_number_in;
            fib_done <= 1'b0;
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                fib_done <= 1'b1;
                fib_number_out <= fib(int'(core_n));
            end else core_cnt <= core_cnt - 1;
        end
    end

    always @(posedge clk) begin
        req_seen <= req;
        num_seen <= req_num;
    end

    // Monitor: predicts the round-robin winner at each ack and scores every response.
    always @(negedge clk) begin
        if (reset) begin
            if (req_ack != 0) begin
                int w;
                logic [3:0] e;
                logic [4:0] n;
                w = -1;
                e = '0;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req_seen[(mptr + k) % 4]) w = (mptr + k) % 4;
                if (w >= 0) e[w] = 1'b1;
                chk("ack_winner", 32'(req_ack), 32'(e));
                if (w >= 0) begin
                    n = num_seen[5*w +: 5];
                    q.push_back('{w, (n > 24 || hang) ? 16'd0 : fib(int'(n)), n > 24 || hang});
                    ack_log.push_back(w);
                    exp_go = n <= 24;
                    exp_num = n;
                end
            end
            if (fib_go) begin
                chk("go_expected", 32'(exp_go), 32'd1);
                chk("go_num", 32'(fib_number_in), 32'(exp_num));
                chk("go_core_live", 32'(fib_reset), 32'd1);
                exp_go = 1'b0;
            end
            if (resp_valid) begin
                if (q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
                else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(x.id));
                    chk("resp_data", 32'(resp_data), 32'(x.data));
                    chk("resp_err", 32'(resp_err), 32'(x.err));
                    chk("go_issued", 32'(exp_go), 32'd0);
                    mptr = (x.id + 1) % 4;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        req = req & ~req_ack;
        if (rnd_en)
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_num[5*i +: 5] = 5'($urandom_range(0, 27));
                end
    endtask

    task automatic do_req(input int i, input logic [4:0] n);
        int c = 0;
        tick();
        req[i] = 1'b1;
        req_num[5*i +: 5] = n;
        while (req[i] && c < 300) begin
            tick();
            c++;
        end
        if (req[i]) chk("ack_timeout", 32'(req[i]), 32'd0);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (!(req == 0 && !busy && !resp_valid && q.size() == 0) && c < 500) begin
            tick();
            c++;
        end
        if (c >= 500) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_go();
        int c = 0;
        while (!fib_go && c < 300) begin
            tick();
            c++;
        end
        if (!fib_go) chk("go_timeout", 32'(fib_go), 32'd1);
    endtask

    initial begin
        int c;
        repeat (3) tick();
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_data", 32'(resp_data), 0);
        chk("rst_err", 32'(resp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_go", 32'(fib_go), 0);
        chk("rst_num_in", 32'(fib_number_in), 0);
        chk("rst_fib_reset", 32'(fib_reset), 0);
        reset = 1'b1;
        tick();
        chk("fib_reset_release", 32'(fib_reset), 1);

        do_req(0, 5'd6);  wait_idle();
        do_req(1, 5'd10); wait_idle();
        do_req(3, 5'd24); wait_idle();

        // Range error: ack next cycle, response the cycle after, core untouched.
        tick();
        req[2] = 1'b1;
        req_num[14:10] = 5'd25;
        tick();
        chk("rerr_ack", 32'(req_ack), 32'b0100);
        chk("rerr_early", 32'(resp_valid), 0);
        tick();
        chk("rerr_valid", 32'(resp_valid), 1);
        chk("rerr_flag", 32'(resp_err), 1);
        chk("rerr_data", 32'(resp_data), 0);
        wait_idle();

        // Pointer is 3 here: 0 wins over 2, then 0 wins over 1 after wrap.
        ack_log.delete();
        tick();
        req = 4'b0101;
        req_num = {5'd0, 5'd5, 5'd0, 5'd5};
        wait_idle();
        tick();
        req = 4'b0011;
        req_num = {5'd0, 5'd0, 5'd7, 5'd9};
        wait_idle();
        chk("order_0", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 0);
        chk("order_1", 32'(ack_log.size() > 1 ? ack_log[1] : -1), 2);
        chk("order_2", 32'(ack_log.size() > 2 ? ack_log[2] : -1), 0);
        chk("order_3", 32'(ack_log.size() > 3 ? ack_log[3] : -1), 1);

        // Hung core: watchdog aborts 64 cycles after go.
        hang = 1'b1;
        tick();
        req[1] = 1'b1;
        req_num[9:5] = 5'd7;
        wait_go();
        c = 0;
        while (fib_reset && c < 200) begin
            tick();
            c++;
        end
        chk("abort_cycles", 32'(c), 32'd64);
        tick();
        chk("abort_pulse_len", 32'(fib_reset), 1);
        chk("abort_resp", 32'(resp_valid), 1);
        chk("abort_idle", 32'(busy), 0);
        wait_idle();
        hang = 1'b0;

        // Reset mid-WAIT drops the job silently.
        lat_fix = 20;
        tick();
        req[2] = 1'b1;
        req_num[14:10] = 5'd10;
        wait_go();
        repeat (3) tick();
        chk("pre_reset_busy", 32'(busy), 1);
        reset = 1'b0;
        req = '0;
        q.delete();
        mptr = 0;
        exp_go = 1'b0;
        repeat (2) tick();
        chk("mid_rst_fib_reset", 32'(fib_reset), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        reset = 1'b1;
        lat_fix = 3;
        do_req(0, 5'd10);
        wait_idle();

        lat_fix = 0;
        rnd_en = 1'b1;
        repeat (600) tick();
        rnd_en = 1'b0;
        wait_idle();
        chk("final_queue_empty", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
